// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by the transmitter (and later the receiver).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; full/empty derived from the occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO; frame format fixed at elaboration.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          TxD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import uart_pkg::*;

  localparam int unsigned CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned CW    = (CPB > 1) ? $clog2(CPB) : 1;
  localparam parity_e     PMODE = parity_e'(PARITY[1:0]);

  tx_state_e            state;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic [DATA_BITS-1:0] head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 last_stop;

  assign s_ready   = !fifo_full;
  assign push      = s_valid && s_ready;
  assign bit_end   = (baud_cnt == CW'(CPB - 1));
  assign last_stop = (state == STOP) && bit_end && (bit_idx == 4'(STOP_BITS - 1));
  // Popping on the final stop cycle lets the next start bit follow with no idle gap.
  assign pop       = !fifo_empty && ((state == IDLE) || last_stop);
  assign busy      = (state != IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      TxD      <= 1'b1;
    end else begin
      // Held at zero in IDLE and wrapped at each bit end, so every state entry starts at zero.
      baud_cnt <= ((state == IDLE) || bit_end) ? '0 : baud_cnt + CW'(1);

      if (pop) begin
        shift   <= head;
        par_bit <= (PMODE == PAR_EVEN) ? ^head : ~^head;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            bit_idx <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PMODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            bit_idx <= '0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_idx == 4'(STOP_BITS - 1)) begin
              bit_idx <= '0;
              state   <= pop ? START : IDLE;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      case (state)
        START:            TxD <= 1'b0;
        DATA:             TxD <= shift[0];
        uart_pkg::PARITY: TxD <= par_bit;
        default:          TxD <= 1'b1;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with a built-in transmit FIFO and a valid/ready input handshake.
- Frame format is set at elaboration: data width, parity mode and stop-bit count.
- Baud divider is derived from clock frequency and baud rate.
- Sits between on-board logic (button/data sources, packet generators) and the board's serial TxD pin, replacing the fixed 8N1 transmitter.

Parameters:
- CLK_FREQ_HZ, 100_000_000, input clock frequency.
- BAUD, 9600, line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD, integer truncation (10416 at defaults).
- DATA_BITS, 8, payload bits per frame, legal 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, legal 1 or 2.
- FIFO_DEPTH, 4, entries; power of two, >= 2.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- s_valid, input, 1, producer has a word on s_data.
- s_ready, output, 1, FIFO can accept a word; equals !full.
- s_data, input, DATA_BITS, payload, LSB sent first.
- TxD, output, 1, serial line, registered; idles high.
- busy, output, 1, frame in progress or FIFO non-empty.
- fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset, while asserted and on the first cycle after release:
  - TxD=1, s_ready=1, busy=0, fifo_count=0.
  - FIFO pointers, baud counter, bit index and state cleared.
  - Reset mid-frame aborts the frame; TxD is high on the next edge and FIFO contents are discarded.
- Push: occurs on the clk edge where s_valid && s_ready. The word is written at the tail and fifo_count increments.
- Full FIFO:
  - s_ready=0; s_valid is ignored and there is no overwrite.
  - Producer must hold s_data stable until accepted.
- Pop: occurs on the edge where state==IDLE and FIFO is non-empty. The head word loads the shift register and state goes to START.
- Simultaneous push and pop: both happen and fifo_count is unchanged.
- Push into an empty FIFO while IDLE:
  - Pop on the next edge.
  - TxD goes low on the edge after that, 2 cycles after acceptance.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TxD=1.
  - START: TxD=0 for CLKS_PER_BIT cycles.
  - DATA: TxD=shift[0]; shift right at each bit end; exits after DATA_BITS bits.
  - PARITY: skipped when PARITY==0. Value = ^data for even, ~^data for odd.
  - STOP: TxD=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Bit timing:
  - Baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - Every bit lasts exactly CLKS_PER_BIT cycles, with no drift between bits.
- Back-to-back frames:
  - At the last stop-bit cycle, if the FIFO is non-empty, pop directly and enter START.
  - No idle cycles between frames.
  - If the FIFO is empty, return to IDLE.
- Frame length in cycles: CLKS_PER_BIT * (1 + DATA_BITS + (PARITY!=0) + STOP_BITS).
- busy = (state!=IDLE) || (fifo_count!=0).
- s_ready and busy are combinational from registered state; TxD is registered.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from fifo_count.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum: PAR_NONE, PAR_ODD, PAR_EVEN.
  - tx_state_e enum: IDLE, START, DATA, PARITY, STOP.
  - Function clks_per_bit(freq, baud).
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - Ports: clk, reset, wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Reused later by the receiver.
- The top level holds the baud counter, FSM and shift register.

Test Plan (sim params CLK_FREQ_HZ=1_000_000, BAUD=100_000, so 10 clocks/bit):
- 8N1, push 0x55 into an idle block → TxD low 2 cycles after acceptance; then 1,0,1,0,1,0,1,0 at 10 cycles each; stop high 10 cycles; busy low after 100 cycles total.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x41 → frame 0,1000001,0(even parity),1,1 = 110 cycles.
- Same configuration with PARITY=1, push 0x41 → parity bit 1.
- FIFO_DEPTH=4, hold s_valid high with 0x01..0x06 during one frame:
  - s_ready drops once 4 words are queued; the 6th word is held until accepted.
  - All six frames are contiguous with no gap.
  - Output order is 0x01..0x06.
- Assert reset in mid-data bit 3 of 0xA5 with 2 words queued → TxD=1 next cycle; fifo_count=0; busy=0; no further frames.
- Push exactly when the last stop cycle pops → fifo_count unchanged that cycle; next frame starts with no gap.
